// File: rtl/pht.sv
// pht: gshare-style pattern history table of 2-bit counters with an in-order queue of indices awaiting resolve
module pht #(
  parameter int width = 4,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [31:0]              pred_pc,
  input  logic [width-1:0]         bhr_in,
  output logic                     pred_ready,
  output logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic [$clog2(depth):0]   occupancy,
  output logic                     resolve_err
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full = (aw+1)'(depth);
  logic [1:0] ctr [2**width];
  logic [width-1:0] q [depth];
  logic [aw-1:0] wp, rp;
  logic [width-1:0] idx, upd_idx;
  logic [1:0] cur, nxt;
  logic accept, pop;
  always_comb begin
    idx = pred_pc[width+1:2] ^ bhr_in;
    pred_taken = ctr[idx][1];
    pred_ready = occupancy != full;
    accept = pred_valid && pred_ready;
    pop = resolve_valid && occupancy != '0;
    upd_idx = q[rp];
    cur = ctr[upd_idx];
    nxt = resolve_taken ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**width; i++) ctr[i] <= 2'b01;
      wp <= '0;
      rp <= '0;
      occupancy <= '0;
      resolve_err <= 1'b0;
    end else begin
      if (pop) ctr[upd_idx] <= nxt;
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      occupancy <= (accept && !pop) ? occupancy + 1'b1 : (pop && !accept) ? occupancy - 1'b1 : occupancy;
      resolve_err <= resolve_valid && occupancy == '0;
    end
  end
  always_ff @(posedge clk)
    if (accept) q[wp] <= idx;
endmodule

// File: tb/tb_pht.sv
// tb_pht: directed and randomized checks of pht against a queue-based reference model
module tb_pht;
  logic clk = 1'b0;
  logic rst, pred_valid, resolve_valid, resolve_taken;
  logic [31:0] pred_pc;
  logic [3:0] bhr_in;
  logic pred_ready, pred_taken, resolve_err;
  logic [2:0] occupancy;
  int tests = 0, fails = 0;
  int mctr [16];
  int mq [$];
  bit merr;

  always #5 clk = ~clk;

  pht #(.width(4), .depth(4)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc), .bhr_in(bhr_in),
    .pred_ready(pred_ready), .pred_taken(pred_taken), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .occupancy(occupancy), .resolve_err(resolve_err)
  );

  function automatic int midx(input logic [31:0] pc, input logic [3:0] bhr);
    return ((int'(pc) >>> 2) & 15) ^ int'(bhr);
  endfunction

  function automatic logic mtaken(input logic [31:0] pc, input logic [3:0] bhr);
    return mctr[midx(pc, bhr)] >= 2;
  endfunction

  task automatic drive(input logic pv, input logic [31:0] pc, input logic [3:0] bhr,
                       input logic rv, input logic rt, input logic r);
    pred_valid = pv; pred_pc = pc; bhr_in = bhr;
    resolve_valid = rv; resolve_taken = rt; rst = r;
    #2;
  endtask

  // Advance the model from the currently driven inputs, then let the DUT clock.
  task automatic tick();
    int sz, i;
    sz = mq.size();
    if (rst) begin
      for (int k = 0; k < 16; k++) mctr[k] = 1;
      mq.delete();
      merr = 0;
    end else begin
      merr = resolve_valid && sz == 0;
      if (resolve_valid && sz != 0) begin
        i = mq.pop_front();
        mctr[i] = resolve_taken ? (mctr[i] == 3 ? 3 : mctr[i] + 1) : (mctr[i] == 0 ? 0 : mctr[i] - 1);
      end
      if (pred_valid && sz != 4) mq.push_back(midx(pred_pc, bhr_in));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 32'h10, 0, 0, 0, 0);
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    tests++; if (pred_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", pred_ready); end
    tests++; if (resolve_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", resolve_err); end
    tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_taken: got %b expected 0", pred_taken); end
  endtask

  task automatic test_predict();
    do_reset();
    drive(1, 32'h10, 0, 0, 0, 0);
    tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL predict_taken: got %b expected 0", pred_taken); end
    tick();
    tests++; if (occupancy !== 3'd1) begin fails++; $display("FAIL predict_occ: got %0d expected 1", occupancy); end
  endtask

  task automatic test_saturation();
    logic up_exp [3] = '{1, 1, 1};
    logic dn_exp [4] = '{1, 0, 0, 0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h10, 0, 0, 0, 0); tick();
      drive(0, 32'h10, 0, 1, 1, 0); tick();
      drive(0, 32'h10, 0, 0, 0, 0);
      tests++; if (pred_taken !== up_exp[k]) begin fails++; $display("FAIL sat_up%0d: got %b expected %b", k, pred_taken, up_exp[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h10, 0, 0, 0, 0); tick();
      drive(0, 32'h10, 0, 1, 0, 0); tick();
      drive(0, 32'h10, 0, 0, 0, 0);
      tests++; if (pred_taken !== dn_exp[k]) begin fails++; $display("FAIL sat_dn%0d: got %b expected %b", k, pred_taken, dn_exp[k]); end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h10, 0, 0, 0, 0); tick();
      drive(0, 32'h10, 0, 1, 1, 0); tick();
    end
    drive(0, 32'h10, 0, 0, 0, 0);
    tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL sat_floor: got %b expected 1", pred_taken); end
  endtask

  task automatic test_full_queue();
    logic rdy_exp [5] = '{1, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h20 + 32'(k * 4), 0, 0, 0, 0);
      tests++; if (pred_ready !== rdy_exp[k]) begin fails++; $display("FAIL full_ready%0d: got %b expected %b", k, pred_ready, rdy_exp[k]); end
      tick();
    end
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
    drive(1, 32'h40, 0, 1, 1, 0);
    tests++; if (pred_ready !== 1'b0) begin fails++; $display("FAIL full_pop_ready: got %b expected 0", pred_ready); end
    tick();
    tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL full_pop_occ: got %0d expected 3", occupancy); end
    drive(1, 32'h40, 0, 0, 0, 0);
    tests++; if (pred_ready !== 1'b1) begin fails++; $display("FAIL refill_ready: got %b expected 1", pred_ready); end
    tick();
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL refill_occ: got %0d expected 4", occupancy); end
  endtask

  task automatic test_index_capture();
    do_reset();
    drive(1, 32'h10, 4'h3, 0, 0, 0); tick();
    drive(0, 32'h10, 4'h0, 1, 1, 0); tick();
    drive(0, 32'h10, 4'h3, 0, 0, 0);
    tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL capture_idx7: got %b expected 1", pred_taken); end
    drive(0, 32'h10, 4'h0, 0, 0, 0);
    tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL capture_idx4: got %b expected 0", pred_taken); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(1, 32'h10, 0, 0, 0, 0); tick();
    drive(1, 32'h10, 0, 1, 1, 0);
    tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL same_pre: got %b expected 0", pred_taken); end
    tick();
    drive(0, 32'h10, 0, 0, 0, 0);
    tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL same_post: got %b expected 1", pred_taken); end
    tests++; if (occupancy !== 3'd1) begin fails++; $display("FAIL same_occ: got %0d expected 1", occupancy); end
  endtask

  task automatic test_error_and_reset();
    do_reset();
    drive(0, 32'h10, 0, 1, 1, 0); tick();
    tests++; if (resolve_err !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b expected 1", resolve_err); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL err_occ: got %0d expected 0", occupancy); end
    drive(0, 32'h10, 0, 0, 0, 0);
    tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL err_ctr: got %b expected 0", pred_taken); end
    tick();
    tests++; if (resolve_err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b expected 0", resolve_err); end
    for (int k = 0; k < 2; k++) begin drive(1, 32'h10, 0, 0, 0, 0); tick(); end
    for (int k = 0; k < 2; k++) begin drive(0, 32'h10, 0, 1, 1, 0); tick(); end
    drive(1, 32'h10, 0, 0, 0, 0); tick();
    drive(1, 32'h14, 0, 1, 1, 1); tick();
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL midrst_occ: got %0d expected 0", occupancy); end
    for (int k = 0; k < 16; k++) begin
      drive(0, 32'(k * 4), 0, 0, 0, 0);
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL midrst_ctr%0d: got %b expected 0", k, pred_taken); end
    end
    drive(0, 0, 0, 1, 1, 0); tick();
    tests++; if (resolve_err !== 1'b1) begin fails++; $display("FAIL postrst_err: got %b expected 1", resolve_err); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pc = {$urandom_range(0, 7), 2'b00} | 32'($urandom) & 32'hFFFF_FFC0;
      drive($urandom_range(0, 2) != 0, pc, 4'($urandom), $urandom_range(0, 2) == 0,
            1'($urandom), $urandom_range(0, 60) == 0);
      tests++; if (pred_taken !== mtaken(pred_pc, bhr_in)) begin fails++; $display("FAIL rnd_taken@%0d: got %b expected %b", n, pred_taken, mtaken(pred_pc, bhr_in)); end
      tests++; if (pred_ready !== (mq.size() != 4)) begin fails++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, pred_ready, mq.size() != 4); end
      tick();
      tests++; if (occupancy !== 3'(mq.size())) begin fails++; $display("FAIL rnd_occ@%0d: got %0d expected %0d", n, occupancy, mq.size()); end
      tests++; if (resolve_err !== merr) begin fails++; $display("FAIL rnd_err@%0d: got %b expected %b", n, resolve_err, merr); end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    test_reset();
    test_predict();
    test_saturation();
    test_full_queue();
    test_index_capture();
    test_same_cycle();
    test_error_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
